ram_1bit_cell: RTL and testbench
================================

Name: ram_1bit_cell

Overview:
- Single-port, bit-wide synchronous RAM: an array of 2**ADDR_WIDTH one-bit storage cells.
- Write and read are enabled independently. Reads are registered with 1-cycle latency.
- Used as a small flag/bit store inside control datapaths.
- Every cell and the read register are cleared by an asynchronous active-low reset.

Parameters:
- ADDR_WIDTH, 4, address width; depth = 2**ADDR_WIDTH cells (16 by default); legal range 1..10.
- RESET_VALUE, 1'b0, value loaded into every cell and into read_data on reset.

Ports:
- clock  input  1  rising-edge clock for all state.
- reset_n  input  1  asynchronous, active-low reset.
- write_enable  input  1  when high at a rising clock edge, write_data is stored at address.
- write_data  input  1  bit to store.
- read_enable  input  1  when high at a rising clock edge, the addressed cell is captured into read_data.
- address  input  ADDR_WIDTH  shared read/write cell index.
- read_data  output  1  registered read result.
- read_valid  output  1  high for exactly the cycle after an accepted read.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset_n low, asynchronous assert):
  - all cells = RESET_VALUE, read_data = RESET_VALUE, read_valid = 0, immediately, without waiting for a clock edge.
  - Deassertion is taken synchronously; the first operation is accepted at the first rising edge with reset_n high.
- Reset mid-operation: a write or read pending at the edge where reset is low is discarded; no cell changes except the reset clear.
- Write: on a rising edge with write_enable=1, mem[address] <= write_data. No output change is caused by a write alone.
- Read: on a rising edge with read_enable=1, read_data <= mem[address] and read_valid <= 1.
  - Latency is 1 cycle: data is visible after the capturing edge.
- Idle read: with read_enable=0 at an edge, read_data holds its previous value and read_valid <= 0.
- Simultaneous read and write to the same address at the same edge: write-first. read_data <= write_data, and the cell is also updated.
- Write-then-read: a write at edge N followed by a read at edge N+1 returns the written value after edge N+1.
- Address: all 2**ADDR_WIDTH indices are valid, with no wrap or out-of-range case. Writes affect only the addressed cell.
- No X propagation: after reset every cell holds a defined value.
- Enables and address are sampled only at rising edges; glitches between edges have no effect.

Test Plan:
- Reset: drive reset_n=0 with no clock edge -> read_data=0 and read_valid=0 immediately. Read all 16 addresses after release -> all 0.
- Basic write/read:
  - Edge 1: address=0, write_enable=1, write_data=1.
  - Edge 2: write_enable=0, read_enable=1.
  - After edge 2: read_data=1, read_valid=1.
- Independence: write 1 to address 5 and 0 to address 6. Reads return 5->1, 6->0, 4->0.
- Hold: read address 5 (read_data=1), then hold read_enable=0 for 3 cycles while writing 0 to address 5 -> read_data stays 1 and read_valid=0. A subsequent read returns 0.
- Collision: address=9 holds 0. Assert write_enable=1, write_data=1 and read_enable=1 at the same edge -> read_data=1 after that edge, and a later read of 9 returns 1.
- Async reset mid-stream: fill all cells with 1, then pulse reset_n low between clock edges -> read_data drops to 0 immediately, and every address reads 0 afterwards.

Source files
------------

// File: rtl/ram_1bit_cell.sv
// ram_1bit_cell: single-port, bit-wide RAM with 2**ADDR_WIDTH cells.
// Writes and reads are enabled independently. Reads are registered and have
// one cycle of latency. Every cell and the read register clear asynchronously
// when reset_n goes low.
//
// Read interface: read_enable high at a rising edge is always accepted. No
// back-pressure exists. read_valid is high for exactly the cycle after an
// accepted read, and read_data holds that result until the next accepted read.
module ram_1bit_cell #(
   parameter int   ADDR_WIDTH  = 4,
   parameter logic RESET_VALUE = 1'b0
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  write_enable,
   input  logic                  write_data,
   input  logic                  read_enable,
   input  logic [ADDR_WIDTH-1:0] address,
   output logic                  read_data,
   output logic                  read_valid
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DEPTH-1:0] r_mem;
   logic             r_read_data;
   logic             r_read_valid;
   logic             w_cell_bit;
   logic             w_read_bit;

   // Select the addressed cell. On a same-edge write, take the incoming bit
   // instead, so the read returns the newly written value (write-first).
   always_comb begin
      w_cell_bit = r_mem[address];
      w_read_bit = write_enable ? write_data : w_cell_bit;
   end

   // Cell array: an asynchronous clear, then a single-cell write on an enabled edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_mem <= {DEPTH{RESET_VALUE}};
      end else if (write_enable) begin
         r_mem[address] <= write_data;
      end
   end

   // Read register: capture on an accepted read. The valid strobe follows read_enable.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_read_data  <= RESET_VALUE;
         r_read_valid <= 1'b0;
      end else begin
         r_read_valid <= read_enable;
         if (read_enable) begin
            r_read_data <= w_read_bit;
         end
      end
   end

   assign read_data  = r_read_data;
   assign read_valid = r_read_valid;

endmodule

// File: tb/tb_ram_1bit_cell.sv
// Testbench for ram_1bit_cell. It runs a set of directed scenarios and then a
// randomized stream of operations. Results are checked against a behavioural
// model made of a bit array and a queue of expected read results.
module tb_ram_1bit_cell;

   localparam int AW    = 4;
   localparam int DEPTH = 1 << AW;

   // ---------------- clock / reset / DUT ----------------
   logic          clock = 1'b0;
   logic          reset_n;
   logic          write_enable;
   logic          write_data;
   logic          read_enable;
   logic [AW-1:0] address;
   logic          read_data;
   logic          read_valid;

   always #5 clock = ~clock;

   ram_1bit_cell #(.ADDR_WIDTH(AW), .RESET_VALUE(1'b0)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .write_enable (write_enable),
      .write_data   (write_data),
      .read_enable  (read_enable),
      .address      (address),
      .read_data    (read_data),
      .read_valid   (read_valid)
   );

   // ---------------- model / scoreboard ----------------
   int         checks = 0;
   int         errors = 0;
   logic       model_mem [DEPTH];
   logic       exp_rd;
   logic       exp_rv;
   logic [0:0] exp_q [$];

   task automatic check_bit(input string tag, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 1'b0;
      exp_rd = 1'b0;
      exp_rv = 1'b0;
      exp_q.delete();
   endtask

   // Drive one operation and let a rising edge take it. Update the model, then
   // check the outputs at the falling edge. The task is entered and left at a
   // falling edge.
   task automatic op(input logic w, input logic d, input logic r,
                     input logic [AW-1:0] a, input string tag);
      logic [0:0] popped;
      write_enable = w;
      write_data   = d;
      read_enable  = r;
      address      = a;
      @(posedge clock);
      if (reset_n) begin
         exp_rv = r;
         if (r) begin
            exp_rd = w ? d : model_mem[a];
            exp_q.push_back(exp_rd);
         end
         if (w) model_mem[a] = d;
      end
      @(negedge clock);
      check_bit({tag, "_valid"}, read_valid, exp_rv);
      if (exp_rv) begin
         popped = exp_q.pop_front();
         check_bit({tag, "_data"}, read_data, popped[0]);
      end else begin
         check_bit({tag, "_hold"}, read_data, exp_rd);
      end
      write_enable = 1'b0;
      read_enable  = 1'b0;
   endtask

   // Pulse reset between clock edges. The outputs must clear immediately.
   task automatic pulse_reset(input string tag);
      reset_n = 1'b0;
      #1;
      model_reset();
      check_bit({tag, "_rd"}, read_data, 1'b0);
      check_bit({tag, "_rv"}, read_valid, 1'b0);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic read_all(input string tag);
      for (int i = 0; i < DEPTH; i++) op(1'b0, 1'b0, 1'b1, AW'(i), tag);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset_n      = 1'b0;
      write_enable = 1'b0;
      write_data   = 1'b0;
      read_enable  = 1'b0;
      address      = '0;
      model_reset();
      #1;
      check_bit("por_rd", read_data, 1'b0);
      check_bit("por_rv", read_valid, 1'b0);
      @(negedge clock);
      reset_n = 1'b1;
      read_all("init");

      // basic write then read
      op(1'b1, 1'b1, 1'b0, 4'd0, "basic_wr");
      op(1'b0, 1'b0, 1'b1, 4'd0, "basic_rd");
      check_bit("basic_rd_one", read_data, 1'b1);

      // independence of neighbouring cells
      op(1'b1, 1'b1, 1'b0, 4'd5, "ind_wr5");
      op(1'b1, 1'b0, 1'b0, 4'd6, "ind_wr6");
      op(1'b0, 1'b0, 1'b1, 4'd5, "ind_rd5");
      op(1'b0, 1'b0, 1'b1, 4'd6, "ind_rd6");
      op(1'b0, 1'b0, 1'b1, 4'd4, "ind_rd4");

      // hold: read_data keeps its value while idle, even as the cell changes
      op(1'b0, 1'b0, 1'b1, 4'd5, "hold_rd5");
      op(1'b1, 1'b0, 1'b0, 4'd5, "hold_wr5");
      op(1'b0, 1'b0, 1'b0, 4'd5, "hold_idle1");
      op(1'b0, 1'b0, 1'b0, 4'd5, "hold_idle2");
      check_bit("hold_still_one", read_data, 1'b1);
      op(1'b0, 1'b0, 1'b1, 4'd5, "hold_reread");
      check_bit("hold_reread_zero", read_data, 1'b0);

      // collision: a read and a write at the same edge are write-first
      op(1'b0, 1'b0, 1'b1, 4'd9, "col_pre");
      op(1'b1, 1'b1, 1'b1, 4'd9, "col_same");
      check_bit("col_same_one", read_data, 1'b1);
      op(1'b0, 1'b0, 1'b1, 4'd9, "col_after");

      // fill with ones, then reset asynchronously mid-stream
      for (int i = 0; i < DEPTH; i++) op(1'b1, 1'b1, 1'b0, AW'(i), "fill");
      op(1'b0, 1'b0, 1'b1, 4'd15, "fill_rd");
      pulse_reset("mid_rst");
      read_all("post_rst");

      // an operation pending at an edge while reset is low is discarded
      op(1'b1, 1'b1, 1'b0, 4'd3, "pre_wr3");
      reset_n = 1'b0;
      model_reset();
      op(1'b1, 1'b1, 1'b1, 4'd3, "rst_edge");
      reset_n = 1'b1;
      op(1'b0, 1'b0, 1'b1, 4'd3, "rst_edge_rd");

      // randomized traffic with occasional resets
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 99) == 0) begin
            pulse_reset("rnd_rst");
         end else begin
            op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), "rnd");
         end
      end
      read_all("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
